muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle HI/LO multiply/divide unit beside the single-cycle execute ALU.
//  Sequences an iterative shift-add multiplier and restoring divider, one bit per cycle.
//  Drives a stall to the pipeline while busy, and owns the architectural HI/LO registers
//  (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// PARAMETERS
//  WIDTH  32  operand width; the iteration count equals WIDTH
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      launch op; sampled only in IDLE
//  op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_val    in   WIDTH  multiplicand / dividend
//  rt_val    in   WIDTH  multiplier / divisor
//  flush     in   1      abort in-flight op (branch/exception squash)
//  hi_we     in   1      MTHI write, honoured only in IDLE
//  lo_we     in   1      MTLO write, honoured only in IDLE
//  wdata     in   WIDTH  MTHI/MTLO data
//  busy      out  1      high in PREP, ITER and FIX
//  stall     out  1      busy | (start & IDLE); holds the pipeline
//  done      out  1      one-cycle pulse, with HI/LO already updated
//  div_zero  out  1      set with done when a DIV/DIVU had rt_val==0; cleared on next start
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=0; busy=done=div_zero=0; internal accumulators=0. Reset is
//   honoured mid-op and discards the operation.
//  FSM:
//   IDLE -start-> PREP
//   PREP -> ITER; latch |operands| for signed ops, record sign of result and remainder,
//    clear count
//   ITER -> stays WIDTH cycles, count 0..WIDTH-1, then -> FIX
//   FIX -> DONE; apply sign correction and write hi/lo
//   DONE -> IDLE; done=1 for exactly this cycle
//  Latency: start sampled at edge E0; hi/lo update at edge E(WIDTH+2); done is high in the
//   following cycle. New start is accepted in IDLE, one cycle after DONE.
//  Multiply: 2*WIDTH product, hi=upper half, lo=lower half.
//   MULT negates the unsigned magnitude product when the operand signs differ.
//  Divide: restoring algorithm on magnitudes. lo=quotient, hi=remainder.
//   Signed: quotient is negated when signs differ; remainder takes the dividend's sign.
//   0x80000000 / -1 gives lo=0x80000000, hi=0. No trap.
//  Divide by zero: full latency; lo=all ones, hi=rs_val as sampled, div_zero=1
//   (signed and unsigned alike).
//  Operands are captured at E0; later changes to rs_val/rt_val are ignored.
//  start while not IDLE: ignored, with no queuing.
//  flush: in PREP/ITER/FIX, state->IDLE at the next edge. hi/lo unchanged, no done pulse.
//   flush in IDLE or DONE has no effect; flush and start together in IDLE: flush wins, no launch.
//  hi_we/lo_we outside IDLE are ignored. In IDLE with start also high: the MT write
//   completes and the op launches in the same edge.
//  stall is combinational from start and state; all other outputs are registered.
// TESTING
//  MULTU 0xFFFFFFFF*2 -> done at E34+1, hi=0x00000001, lo=0xFFFFFFFE, busy high 34 cycles
//  MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF
//  DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234, div_zero=1 with done; next start clears it
//  flush 10 cycles after start (prior hi=lo=0xA5A5A5A5) -> IDLE next edge, no done,
//   hi/lo unchanged
//  start pulses and hi_we while busy -> ignored; one done only; hi keeps the op result
//  rst_n low mid-ITER -> hi=lo=0, busy=0 immediately; no done after release

Source files
------------

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle multiply/divide unit that sits beside the single-cycle execute
// ALU and owns the architectural HI/LO registers.  It runs an iterative
// shift-add multiplier and a restoring divider, one result bit per cycle, and
// holds the pipeline through stall while an operation is in flight.
// Supported operations: MULT, MULTU, DIV, DIVU (via start/op) and MTHI, MTLO
// (via hi_we/lo_we).
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset, discards any op
//   start     in   1      launch op; only looked at while idle
//   op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val    in   WIDTH  multiplicand / dividend, captured at launch
//   rt_val    in   WIDTH  multiplier / divisor, captured at launch
//   flush     in   1      abort an in-flight op, HI/LO left untouched
//   hi_we     in   1      MTHI write, idle only
//   lo_we     in   1      MTLO write, idle only
//   wdata     in   WIDTH  MTHI/MTLO data
//   busy      out  1      op in flight (prep, iterate, fix-up)
//   stall     out  1      busy, or a start being accepted this cycle
//   done      out  1      one-cycle pulse once HI/LO hold the result
//   div_zero  out  1      last divide had a zero divisor
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operands and opcode as captured at launch.
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] rt_q;

  // Shared iteration datapath.  Multiply: {acc_hi, acc_lo} is the running
  // product with the multiplier shifting out of acc_lo.  Divide: acc_hi is the
  // partial remainder, acc_lo shifts the dividend out and the quotient in.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mag_b;
  logic [CNT_W-1:0] count;
  logic             neg_res;
  logic             neg_rem;

  logic             is_div;
  logic             is_signed;
  logic             idle;
  logic             launch;
  logic             abort;
  logic             last_iter;

  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign idle      = (state == S_IDLE);
  // flush beats start when both arrive together in idle.
  assign launch    = idle & start & ~flush;
  assign abort     = flush & ((state == S_PREP) | (state == S_ITER) | (state == S_FIX));
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  assign stall = busy | (start & idle);

  // Sign handling: the iteration always runs on magnitudes.  The most negative
  // value maps onto itself, which is the correct unsigned magnitude.
  assign rs_neg = is_signed & rs_q[WIDTH-1];
  assign rt_neg = is_signed & rt_q[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_q : rs_q;
  assign rt_mag = rt_neg ? -rt_q : rt_q;

  // One shift-add multiply step and one restoring divide step.  The
  // remainder is always below the divisor, so dropping the top bit of the
  // subtraction is safe when the trial succeeds.
  assign mul_addend = acc_lo[0] ? mag_b : '0;
  assign mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};
  assign div_shift  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge     = (div_shift >= {1'b0, mag_b});
  assign div_sub    = div_shift[WIDTH-1:0] - mag_b;

  // Sign fix-up applied when the result is written back.
  assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  // State register plus the registered busy/done outputs, which are derived
  // from the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_PREP) | (state_nxt == S_ITER) | (state_nxt == S_FIX);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Next-state logic; an abort overrides the normal sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_PREP;
      S_PREP:  state_nxt = S_ITER;
      S_ITER:  if (last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Datapath and architectural registers.  Iteration registers may update
  // during an aborted cycle; that is harmless because the next launch
  // reloads them.  Only the HI/LO write-back must be suppressed on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mag_b    <= '0;
      count    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (launch) begin
            op_q     <= op;
            rs_q     <= rs_val;
            rt_q     <= rt_val;
            div_zero <= 1'b0;
          end
        end
        S_PREP: begin
          acc_hi  <= '0;
          count   <= '0;
          neg_res <= rs_neg ^ rt_neg;
          if (is_div) begin
            acc_lo  <= rs_mag;
            mag_b   <= rt_mag;
            neg_rem <= rs_neg;
          end else begin
            acc_lo  <= rt_mag;
            mag_b   <= rs_mag;
            neg_rem <= 1'b0;
          end
        end
        S_ITER: begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!flush) begin
            if (is_div) begin
              // A zero divisor runs the full latency and then reports the
              // raw dividend as remainder with an all-ones quotient.
              if (rt_q == '0) begin
                hi       <= rs_q;
                lo       <= '1;
                div_zero <= 1'b1;
              end else begin
                hi <= rem_fix;
                lo <= quo_fix;
              end
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed bench for muldiv_sequencer.  A reference model tracks the expected
// HI/LO contents and op timeline with plain 64-bit arithmetic and a cycle
// countdown; a compare process checks every output against it on each
// falling edge, and the directed sequence adds literal expectations.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam int LATENCY = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         flush = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         stall;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model state.
  int           remaining = 0;
  bit           exp_done = 1'b0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;
  logic [W-1:0] pend_hi = '0;
  logic [W-1:0] pend_lo = '0;
  logic         pend_dz = 1'b0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checkOutput(name, W'(act), W'(exp));
  endtask

  // Architectural result of one operation, straight from the arithmetic rules.
  function automatic void modelOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] pu;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin
        q = sa * sb;
        h = q[63:32];
        l = q[31:0];
      end
      2'b01: begin
        pu = {32'b0, a} * {32'b0, b};
        h  = pu[63:32];
        l  = pu[31:0];
      end
      default: begin
        if (b == '0) begin
          h  = a;
          l  = '1;
          dz = 1'b1;
        end else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          h = r[31:0];
          l = q[31:0];
        end else begin
          h = a % b;
          l = a / b;
        end
      end
    endcase
  endfunction

  // Timeline model: an accepted op keeps the unit busy for LATENCY edges,
  // then the result lands and done shows for one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining = 0;
      exp_done  = 1'b0;
      exp_hi    = '0;
      exp_lo    = '0;
      exp_dz    = 1'b0;
    end else if (exp_done) begin
      exp_done = 1'b0;
    end else if (remaining > 0) begin
      if (flush) begin
        remaining = 0;
      end else begin
        remaining--;
        if (remaining == 0) begin
          exp_hi   = pend_hi;
          exp_lo   = pend_lo;
          exp_dz   = pend_dz;
          exp_done = 1'b1;
        end
      end
    end else begin
      if (hi_we) exp_hi = wdata;
      if (lo_we) exp_lo = wdata;
      if (start && !flush) begin
        modelOp(op, rs_val, rt_val, pend_hi, pend_lo, pend_dz);
        remaining = LATENCY;
        exp_dz    = 1'b0;
      end
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (check_en) begin
      checkFlag("model_busy", busy, remaining > 0);
      checkFlag("model_done", done, exp_done);
      checkFlag("model_stall", stall, (remaining > 0) || (start && remaining == 0 && !exp_done));
      checkFlag("model_div_zero", div_zero, exp_dz);
      checkOutput("model_hi", hi, exp_hi);
      checkOutput("model_lo", lo, exp_lo);
    end
  end

  // Drive one cycle of inputs, then return to quiet with scrambled operands
  // so that late operand changes are exercised.
  task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic f, input logic hw, input logic lw, input logic [W-1:0] wd);
    start  = s;
    op     = o;
    rs_val = a;
    rt_val = b;
    flush  = f;
    hi_we  = hw;
    lo_we  = lw;
    wdata  = wd;
    @(posedge clk);
    #1;
    start  = 1'b0;
    flush  = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    op     = ~o;
    rs_val = ~a;
    rt_val = a ^ b;
    wdata  = ~wd;
  endtask

  task automatic waitDone(output int cyc, output int bcnt);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    bcnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done, want done within 200 cycles");
    end
  endtask

  task automatic countDones(input int n, output int d);
    d = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) d++;
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                       output int cyc, output int bcnt);
    applyStimulus(1'b1, o, a, b, 1'b0, 1'b0, 1'b0, '0);
    waitDone(cyc, bcnt);
    checkOutput({name, "_hi"}, hi, eh);
    checkOutput({name, "_lo"}, lo, el);
    checkFlag({name, "_div_zero"}, div_zero, edz);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int bcnt;
    int d;

    // Reset state.
    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_hi", hi, '0);
    checkOutput("reset_lo", lo, '0);
    checkFlag("reset_busy", busy, 1'b0);
    checkFlag("reset_done", done, 1'b0);
    checkFlag("reset_div_zero", div_zero, 1'b0);
    checkFlag("reset_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Multiply and divide results with latency checks on the first one.
    runOp("multu", 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0, cyc, bcnt);
    checkOutput("multu_done_cycle", W'(cyc), W'(LATENCY + 1));
    checkOutput("multu_busy_cycles", W'(bcnt), W'(LATENCY));
    runOp("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, cyc, bcnt);
    runOp("div_neg_dividend", 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, cyc, bcnt);
    runOp("div_neg_divisor", 2'b10, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, cyc, bcnt);
    runOp("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, cyc, bcnt);
    runOp("mult_big", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, cyc, bcnt);
    runOp("divu", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0, cyc, bcnt);

    // Divide by zero, flag persistence, then cleared by the next launch.
    runOp("divu_zero", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, cyc, bcnt);
    checkOutput("divu_zero_latency", W'(cyc), W'(LATENCY + 1));
    @(negedge clk);
    checkFlag("div_zero_held", div_zero, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b01, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkFlag("div_zero_cleared", div_zero, 1'b0);
    waitDone(cyc, bcnt);
    checkOutput("multu_small_lo", lo, 32'd42);
    @(posedge clk);
    #1;
    runOp("div_zero_signed", 2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, cyc, bcnt);

    // MTHI together with start: the write lands and the op launches.
    applyStimulus(1'b1, 2'b01, 32'd2, 32'd3, 1'b0, 1'b1, 1'b0, 32'h55);
    @(negedge clk);
    checkOutput("mthi_with_start_hi", hi, 32'h55);
    checkFlag("mthi_with_start_busy", busy, 1'b1);
    waitDone(cyc, bcnt);
    checkOutput("mthi_with_start_res_hi", hi, 32'h0);
    checkOutput("mthi_with_start_res_lo", lo, 32'd6);
    @(posedge clk);
    #1;

    // flush and start together in idle: no launch.
    applyStimulus(1'b1, 2'b01, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkFlag("flush_start_no_launch", busy, 1'b0);
    @(posedge clk);
    #1;

    // start and MT writes while busy are ignored; exactly one done.
    applyStimulus(1'b1, 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 2'b10, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1, 32'hDEAD);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 2'b11, 32'd9, 32'd2, 1'b0, 1'b1, 1'b0, 32'hBEEF);
    countDones(60, d);
    checkOutput("busy_ignore_done_count", W'(d), W'(1));
    checkOutput("busy_ignore_hi", hi, 32'h0);
    checkOutput("busy_ignore_lo", lo, 32'd12);
    @(posedge clk);
    #1;

    // Flush 10 cycles after start leaves HI/LO alone and gives no done.
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5);
    applyStimulus(1'b1, 2'b01, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0, 1'b0, '0);
    repeat (9) @(posedge clk);
    #1;
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkFlag("flush_busy", busy, 1'b0);
    countDones(50, d);
    checkOutput("flush_done_count", W'(d), W'(0));
    checkOutput("flush_hi", hi, 32'hA5A5_A5A5);
    checkOutput("flush_lo", lo, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of the iteration.
    applyStimulus(1'b1, 2'b01, 32'h1234_5678, 32'h9, 1'b0, 1'b0, 1'b0, '0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_hi", hi, 32'h0);
    checkOutput("midop_reset_lo", lo, 32'h0);
    checkFlag("midop_reset_busy", busy, 1'b0);
    checkFlag("midop_reset_done", done, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    countDones(50, d);
    checkOutput("midop_reset_done_count", W'(d), W'(0));
    checkFlag("midop_reset_idle", busy, 1'b0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
